// File: rtl/pc_jump_ctrl.sv
// Program counter owner for the fetch stage: sequencing of increment,
// jump redirect, deferred redirect under stall/imem-busy, and IF flush.
module pc_jump_ctrl #(
  parameter int                 ADDR_W     = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC   = '0,
  parameter bit                 DELAY_SLOT = 1'b1,
  parameter int                 CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              stall,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus1,
  output logic              if_flush,
  output logic              jump_pending,
  output logic [CNT_W-1:0]  jump_count
);

  typedef enum logic {
    ST_RUN,
    ST_PEND
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_pend_addr;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_adv;
  logic              w_in_run;
  logic              w_in_pend;
  logic              w_apply;
  logic              w_cnt_max;
  logic [ADDR_W-1:0] w_tgt;
  logic [ADDR_W-1:0] w_pc_inc;

  assign w_adv     = ~stall & imem_ready;
  assign w_in_run  = (r_state == ST_RUN);
  assign w_in_pend = (r_state == ST_PEND);
  assign w_cnt_max = &r_cnt;
  assign w_pc_inc  = r_pc + ADDR_W'(1);

  // a fresh target in the exit cycle beats the latched one
  assign w_tgt = jump_en ? jump_addr : r_pend_addr;

  assign w_apply = ~rst & w_adv &
                   ((w_in_run & jump_en) | w_in_pend);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_pc        <= RESET_PC;
      r_pend_addr <= '0;
      r_cnt       <= '0;
    end else begin
      unique case (1'b1)
        w_in_run: begin
          if (jump_en) begin
            if (w_adv) begin
              r_pc <= jump_addr;
            end else begin
              r_pend_addr <= jump_addr;
              r_state     <= ST_PEND;
            end
          end else if (w_adv) begin
            r_pc <= w_pc_inc;
          end
        end
        w_in_pend: begin
          if (jump_en) begin
            r_pend_addr <= jump_addr;
          end
          if (w_adv) begin
            r_pc    <= w_tgt;
            r_state <= ST_RUN;
          end
        end
        default: begin
          r_state <= ST_RUN;
        end
      endcase
      if (w_apply && !w_cnt_max) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign pc           = r_pc;
  assign pc_plus1     = w_pc_inc;
  assign if_flush     = DELAY_SLOT ? 1'b0 : w_apply;
  assign jump_pending = ~rst & w_in_pend;
  assign jump_count   = r_cnt;

endmodule

// File: tb/tb_pc_jump_ctrl.sv
// Scoreboard bench for pc_jump_ctrl: two builds share stimulus,
// one with flush enabled and wide counter, one with delay slot and CNT_W=2.
module tb_pc_jump_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_en;
  logic [15:0] jump_addr;
  logic        stall;
  logic        imem_ready;

  logic [15:0] pc0, pp0, cnt0;
  logic        fl0, pd0;
  logic [15:0] pc1, pp1;
  logic [1:0]  cnt1;
  logic        fl1, pd1;

  always #5 clk = ~clk;

  pc_jump_ctrl #(
    .ADDR_W(16), .RESET_PC(16'h0000),
    .DELAY_SLOT(1'b0), .CNT_W(16)
  ) u_dut0 (
    .clk(clk), .rst(rst),
    .jump_en(jump_en), .jump_addr(jump_addr),
    .stall(stall), .imem_ready(imem_ready),
    .pc(pc0), .pc_plus1(pp0),
    .if_flush(fl0), .jump_pending(pd0),
    .jump_count(cnt0)
  );

  pc_jump_ctrl #(
    .ADDR_W(16), .RESET_PC(16'h0000),
    .DELAY_SLOT(1'b1), .CNT_W(2)
  ) u_dut1 (
    .clk(clk), .rst(rst),
    .jump_en(jump_en), .jump_addr(jump_addr),
    .stall(stall), .imem_ready(imem_ready),
    .pc(pc1), .pc_plus1(pp1),
    .if_flush(fl1), .jump_pending(pd1),
    .jump_count(cnt1)
  );

  typedef struct packed {
    logic [15:0] pc;
    logic        fl;
    logic        pd;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  // monitor: outputs are presented every cycle, checked mid-cycle
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [1:0] c1;
      e  = q.pop_front();
      c1 = (e.cnt > 16'd3) ? 2'd3 : e.cnt[1:0];
      chk("pc0", pc0, e.pc);
      chk("pc_plus1_0", pp0, e.pc + 16'd1);
      chk("if_flush0", {15'd0, fl0}, {15'd0, e.fl});
      chk("pending0", {15'd0, pd0}, {15'd0, e.pd});
      chk("count0", cnt0, e.cnt);
      chk("pc1", pc1, e.pc);
      chk("if_flush1", {15'd0, fl1}, 16'd0);
      chk("pending1", {15'd0, pd1}, {15'd0, e.pd});
      chk("count1", {14'd0, cnt1}, {14'd0, c1});
    end
  end

  task automatic step(input logic r, input logic je,
                      input logic [15:0] a, input logic s,
                      input logic rdy, input logic [15:0] epc,
                      input logic efl, input logic epd,
                      input logic [15:0] ecnt);
    @(posedge clk);
    #1;
    rst        = r;
    jump_en    = je;
    jump_addr  = a;
    stall      = s;
    imem_ready = rdy;
    q.push_back('{pc: epc, fl: efl, pd: epd, cnt: ecnt});
  endtask

  initial begin
    rst = 1'b1; jump_en = 1'b0; jump_addr = '0;
    stall = 1'b0; imem_ready = 1'b1;
    // reset state, then plain increments
    step(1, 0, 16'h0000, 0, 1, 16'h0000, 0, 0, 0);
    step(0, 0, 16'h0000, 0, 1, 16'h0000, 0, 0, 0);
    step(0, 0, 16'h0000, 0, 1, 16'h0001, 0, 0, 0);
    step(0, 0, 16'h0000, 0, 1, 16'h0002, 0, 0, 0);
    step(0, 0, 16'h0000, 0, 1, 16'h0003, 0, 0, 0);
    step(0, 1, 16'h0010, 0, 1, 16'h0004, 1, 0, 0);
    // unstalled jump 0x10 -> 0x100
    step(0, 1, 16'h0100, 0, 1, 16'h0010, 1, 0, 1);
    step(0, 0, 16'h0000, 0, 1, 16'h0100, 0, 0, 2);
    step(0, 1, 16'h0020, 0, 1, 16'h0101, 1, 0, 2);
    // stalled jump held for three cycles
    step(0, 1, 16'h0200, 1, 1, 16'h0020, 0, 0, 3);
    step(0, 0, 16'h0000, 1, 1, 16'h0020, 0, 1, 3);
    step(0, 0, 16'h0000, 1, 1, 16'h0020, 0, 1, 3);
    step(0, 0, 16'h0000, 0, 1, 16'h0020, 1, 1, 3);
    step(0, 0, 16'h0000, 0, 1, 16'h0200, 0, 0, 4);
    // imem busy, target replaced while pending
    step(0, 1, 16'h0200, 0, 0, 16'h0201, 0, 0, 4);
    step(0, 1, 16'h0300, 0, 0, 16'h0201, 0, 1, 4);
    step(0, 0, 16'h0000, 0, 0, 16'h0201, 0, 1, 4);
    step(0, 0, 16'h0000, 0, 1, 16'h0201, 1, 1, 4);
    // pending exit with a fresh jump in the same cycle
    step(0, 1, 16'h0400, 1, 1, 16'h0300, 0, 0, 5);
    step(0, 1, 16'h0500, 0, 1, 16'h0300, 1, 1, 5);
    // wrap from 0xFFFF
    step(0, 1, 16'hFFFF, 0, 1, 16'h0500, 1, 0, 6);
    step(0, 0, 16'h0000, 0, 1, 16'hFFFF, 0, 0, 7);
    step(0, 0, 16'hA5A5, 1, 1, 16'h0000, 0, 0, 7);
    step(0, 0, 16'h5A5A, 0, 0, 16'h0000, 0, 0, 7);
    step(0, 0, 16'h0000, 0, 1, 16'h0000, 0, 0, 7);
    // reset while pending with jump_en high
    step(0, 1, 16'h0700, 1, 1, 16'h0001, 0, 0, 7);
    step(1, 1, 16'h0800, 0, 1, 16'h0001, 0, 0, 7);
    step(0, 0, 16'h0000, 0, 1, 16'h0000, 0, 0, 0);
    step(0, 0, 16'h0000, 0, 1, 16'h0001, 0, 0, 0);
    begin
      int k;
      k = 0;
      while (q.size() > 0 && k < 20) begin
        @(posedge clk);
        k++;
      end
      if (q.size() > 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL drain: %0d left, expected 0", q.size());
      end
    end
    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_jump_ctrl.md
Name: pc_jump_ctrl

Overview:
- Consumer end of the jump-enable path: takes the resolved jump_en and target address from the ID stage and owns the program counter register.
- Sequences PC update, redirect and IF-stage flush, including redirects that arrive while the pipeline is stalled or instruction memory is busy.
- Sits between the hazard/stall logic, the instruction-memory port and the IF/ID pipeline register.

Parameters:
- ADDR_W, 16, PC and jump-target width.
- RESET_PC, 16'h0000, PC value loaded on reset.
- DELAY_SLOT, 1, 1: instruction in IF at redirect time is a delay slot and is kept; 0: it is flushed.
- CNT_W, 16, width of the taken-jump counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- jump_en  in  1  redirect request from the jump-enable mux, valid in current cycle.
- jump_addr  in  ADDR_W  redirect target, qualified by jump_en.
- stall  in  1  hazard stall; PC must hold.
- imem_ready  in  1  instruction memory accepts a fetch this cycle; low when the port is taken by a data access.
- pc  out  ADDR_W  current fetch address (register output).
- pc_plus1  out  ADDR_W  pc + 1, modulo 2^ADDR_W (combinational).
- if_flush  out  1  load a bubble into IF/ID this cycle.
- jump_pending  out  1  a redirect is latched but not yet applied.
- jump_count  out  CNT_W  number of applied redirects, saturating.

Behaviour:
- advance = ~stall & imem_ready, combinational.
- State machine: RUN, PEND. Internal pend_addr register, ADDR_W bits.
- Reset (rst high at clk edge):
  - pc <= RESET_PC; state <= RUN; pend_addr <= 0; jump_count <= 0.
  - Outputs during and after the reset cycle: if_flush = 0, jump_pending = 0.
  - Reset overrides everything, including a PEND state or a simultaneous jump_en.
- RUN:
  - jump_en & advance: pc <= jump_addr. Redirect applied; stay in RUN.
  - jump_en & ~advance: pend_addr <= jump_addr; go to PEND; pc holds.
  - ~jump_en & advance: pc <= pc + 1. Wraps from all-ones to 0.
  - ~jump_en & ~advance: pc holds.
- PEND:
  - jump_pending = 1.
  - jump_en high: pend_addr <= jump_addr, so the latest target wins. This covers a stalled ID stage re-asserting the same branch.
  - advance: pc <= (jump_en ? jump_addr : pend_addr); go to RUN. Redirect applied.
  - ~advance: pc holds.
  - Sequential increment never occurs in PEND.
- Applied redirect: the single cycle in which pc is loaded from jump_addr or pend_addr.
  - Exactly one applied redirect per RUN→RUN jump or per PEND→RUN exit.
- if_flush, combinational:
  - DELAY_SLOT = 0: high in each applied-redirect cycle, otherwise 0.
  - DELAY_SLOT = 1: tied 0.
- jump_count: increments by 1 on each applied redirect and saturates at all-ones.
  - Repeated jump_en while in PEND counts once.
- Latency:
  - Unstalled jump_en in cycle N gives pc = target in cycle N+1.
  - Stalled jump_en gives pc = target one cycle after the first advance cycle.
- pc_plus1 always reflects the registered pc, not the next value.
- jump_en with X/undriven jump_addr while jump_en = 0 must not affect state.

Test Plan:
- Reset with RESET_PC = 16'h0000, then 4 cycles with advance = 1 and no jump → pc sequence 0,1,2,3,4; if_flush = 0; jump_count = 0.
- pc = 16'h0010, jump_en = 1, jump_addr = 16'h0100, advance = 1 → next cycle pc = 16'h0100, jump_count = 1.
  - DELAY_SLOT = 0: if_flush = 1 in the jump cycle only.
  - DELAY_SLOT = 1: if_flush = 0.
- pc = 16'h0020, stall = 1 for 3 cycles with jump_en = 1, jump_addr = 16'h0200 in the first cycle only → pc holds 16'h0020 and jump_pending = 1 for 3 cycles.
  - First cycle with stall = 0: pc becomes 16'h0200 next cycle, jump_count = 1.
- In PEND with pend_addr = 16'h0200, imem_ready = 0, jump_en re-asserted with 16'h0300 → on the first imem_ready = 1 cycle, pc loads 16'h0300; jump_count increases by exactly 1.
- pc = 16'hFFFF, advance = 1 → pc = 16'h0000.
  - Separately, jump_count preset to all-ones via repeated jumps (CNT_W = 2 build) stays at 3 after a further jump.
- rst asserted while in PEND with jump_en = 1 → next cycle pc = RESET_PC, jump_pending = 0, jump_count = 0, if_flush = 0.
